// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler
//   Arbitrates the single ADC124S051 SPI reader between two requesters:
//   the PWM-synchronous phase-current pair (Iv then Iu, atomic, high
//   priority) and two low-priority aux channels served round-robin.
//   Enforces a CS-high gap between frames, a per-frame timeout with a
//   sticky fault, and reports dropped current triggers.
// Ports
//   iClk, iRst_n      clock, asynchronous active-low reset
//   iEn               scheduler enable (low: finish current pair/transfer, then idle)
//   iCurTrig          PWM centre trigger, rising edge requests the current pair
//   iAuxReq           level request for one aux conversion
//   iFault_clr        pulse, clears oFault
//   oRd_en, oAddr     start pulse and channel address to the SPI reader
//   iRd_done, iData   reader done strobe (data valid on its falling edge) and result
//   oIv, oIu          latest current samples, updated together with oCur_valid
//   oAux0, oAux1      latest aux samples, oAux_valid/oAux_ch flag the update
//   oCur_overrun      pulse, a current trigger was dropped
//   oFault            sticky reader-timeout fault
module adc_sample_scheduler #(
  parameter int         DATA_W  = 12,
  parameter logic [1:0] CH_IV   = 2'd2,
  parameter logic [1:0] CH_IU   = 2'd3,
  parameter logic [1:0] CH_AUX0 = 2'd0,
  parameter logic [1:0] CH_AUX1 = 2'd1,
  parameter int         CS_GAP  = 8,
  parameter int         TIMEOUT = 400
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iEn,
  input  logic              iCurTrig,
  input  logic              iAuxReq,
  input  logic              iFault_clr,
  output logic              oRd_en,
  output logic [1:0]        oAddr,
  input  logic              iRd_done,
  input  logic [DATA_W-1:0] iData,
  output logic [DATA_W-1:0] oIv,
  output logic [DATA_W-1:0] oIu,
  output logic [DATA_W-1:0] oAux0,
  output logic [DATA_W-1:0] oAux1,
  output logic              oCur_valid,
  output logic              oAux_valid,
  output logic              oAux_ch,
  output logic              oCur_overrun,
  output logic              oFault
);

  localparam int TO_W  = $clog2(TIMEOUT);
  localparam int GAP_W = $clog2(CS_GAP);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  state_t            state;
  logic              trigPrev, donePrev;
  logic              curPend;    // trigger accepted, pair not yet started
  logic              curActive;  // pair in progress (first ISSUE until back to IDLE)
  logic              seqCur;     // running sequence is the current pair
  logic              curIdx;     // 0: Iv frame, 1: Iu frame
  logic              auxRr;      // next aux channel to serve
  logic              auxCh;      // aux channel of the running transfer
  logic              doneSeen;   // reader answered, timeout no longer armed
  logic [TO_W-1:0]   toCnt;
  logic [GAP_W-1:0]  gapCnt;
  logic [DATA_W-1:0] ivShadow;   // Iv held back so Iv/Iu publish together

  logic       trigEdge, doneFall;
  logic [1:0] addrSel;

  assign trigEdge = iCurTrig & ~trigPrev;
  assign doneFall = ~iRd_done & donePrev;
  assign addrSel  = seqCur ? (curIdx ? CH_IU : CH_IV) : (auxCh ? CH_AUX1 : CH_AUX0);

  // IDLE is only entered after a full GAP, so the gap is always expired there.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state        <= IDLE;
      trigPrev     <= 1'b0;
      donePrev     <= 1'b0;
      curPend      <= 1'b0;
      curActive    <= 1'b0;
      seqCur       <= 1'b0;
      curIdx       <= 1'b0;
      auxRr        <= 1'b0;
      auxCh        <= 1'b0;
      doneSeen     <= 1'b0;
      toCnt        <= '0;
      gapCnt       <= GAP_LAST;
      ivShadow     <= '0;
      oRd_en       <= 1'b0;
      oAddr        <= CH_AUX0;
      oIv          <= '0;
      oIu          <= '0;
      oAux0        <= '0;
      oAux1        <= '0;
      oCur_valid   <= 1'b0;
      oAux_valid   <= 1'b0;
      oAux_ch      <= 1'b0;
      oCur_overrun <= 1'b0;
      oFault       <= 1'b0;
    end else begin
      trigPrev     <= iCurTrig;
      donePrev     <= iRd_done;
      oRd_en       <= 1'b0;
      oCur_valid   <= 1'b0;
      oAux_valid   <= 1'b0;
      oCur_overrun <= 1'b0;

      // A timeout later in this block overrides the clear.
      if (iFault_clr) oFault <= 1'b0;

      if (trigEdge && (curPend || curActive)) oCur_overrun <= 1'b1;
      else if (trigEdge && iEn && !oFault)    curPend      <= 1'b1;
      if (!iEn || oFault) curPend <= 1'b0;

      case (state)
        IDLE: begin
          if (iEn && !oFault) begin
            if (curPend) begin
              state     <= ISSUE;
              seqCur    <= 1'b1;
              curIdx    <= 1'b0;
              curActive <= 1'b1;
            end else if (iAuxReq) begin
              state  <= ISSUE;
              seqCur <= 1'b0;
              auxCh  <= auxRr;
            end
          end
        end
        ISSUE: begin
          oRd_en   <= 1'b1;
          oAddr    <= addrSel;
          toCnt    <= '0;
          doneSeen <= 1'b0;
          state    <= WAIT;
          if (seqCur && !curIdx) curPend <= 1'b0;
        end
        WAIT: begin
          if (iRd_done) doneSeen <= 1'b1;
          if (doneFall) begin
            state  <= GAP;
            gapCnt <= '0;
            if (seqCur) begin
              if (!curIdx) begin
                ivShadow <= iData;
              end else begin
                oIv        <= ivShadow;
                oIu        <= iData;
                oCur_valid <= 1'b1;
              end
            end else begin
              if (auxCh) oAux1 <= iData;
              else       oAux0 <= iData;
              oAux_ch    <= auxCh;
              oAux_valid <= 1'b1;
              auxRr      <= ~auxRr;
            end
          end else if (!doneSeen && !iRd_done) begin
            if (toCnt == TO_LAST) begin
              // Abort: nothing published; clearing seqCur stops the pair.
              oFault <= 1'b1;
              seqCur <= 1'b0;
              state  <= GAP;
              gapCnt <= '0;
            end else begin
              toCnt <= toCnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (gapCnt == GAP_LAST) begin
            if (seqCur && !curIdx) begin
              // Pair is atomic: Iu follows Iv regardless of iEn or aux requests.
              state  <= ISSUE;
              curIdx <= 1'b1;
            end else begin
              state     <= IDLE;
              seqCur    <= 1'b0;
              curActive <= 1'b0;
            end
          end else begin
            gapCnt <= gapCnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
module tb_adc_sample_scheduler;
  localparam int CS_GAP  = 8;
  localparam int TIMEOUT = 400;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic        iEn = 1'b0;
  logic        iCurTrig = 1'b0;
  logic        iAuxReq = 1'b0;
  logic        iFault_clr = 1'b0;
  logic        iRd_done;
  logic [11:0] iData;
  logic        oRd_en;
  logic [1:0]  oAddr;
  logic [11:0] oIv, oIu, oAux0, oAux1;
  logic        oCur_valid, oAux_valid, oAux_ch, oCur_overrun, oFault;

  adc_sample_scheduler dut (
    .iClk(iClk), .iRst_n(iRst_n), .iEn(iEn), .iCurTrig(iCurTrig),
    .iAuxReq(iAuxReq), .iFault_clr(iFault_clr), .oRd_en(oRd_en), .oAddr(oAddr),
    .iRd_done(iRd_done), .iData(iData), .oIv(oIv), .oIu(oIu),
    .oAux0(oAux0), .oAux1(oAux1), .oCur_valid(oCur_valid), .oAux_valid(oAux_valid),
    .oAux_ch(oAux_ch), .oCur_overrun(oCur_overrun), .oFault(oFault)
  );

  always #5 iClk = ~iClk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rstEpoch = 0;
  bit readerDead = 1'b0;
  int ovrCnt = 0;
  int faultCyc = -1;

  // Observed events
  int          rdCyc[$];
  logic [1:0]  rdAddr[$];
  logic [11:0] curIv[$], curIu[$];
  logic        auxChQ[$];
  logic [11:0] auxValQ[$];
  // Reader transaction log
  logic [1:0]  logAddr[$];
  logic [11:0] logData[$];
  int          fallCyc[$];
  logic [11:0] forceQ[$];

  task automatic chkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitIssue(input int target, input string tag);
    int budget;
    budget = 0;
    while (rdAddr.size() < target && budget < 3000) begin
      @(negedge iClk);
      budget++;
    end
    chkEq({tag, "_issue"}, 32'(rdAddr.size() >= target), 1);
  endtask

  task automatic waitQuiet(input string tag);
    int n, still, budget;
    n = rdAddr.size(); still = 0; budget = 0;
    while (still < 80 && budget < 20000) begin
      @(negedge iClk);
      budget++;
      if (rdAddr.size() != n) begin
        n = rdAddr.size();
        still = 0;
      end else begin
        still++;
      end
    end
    chkEq({tag, "_quiet"}, 32'(still >= 80), 1);
  endtask

  task automatic trigPulse();
    iCurTrig = 1'b1;
    repeat (2) @(negedge iClk);
    iCurTrig = 1'b0;
  endtask

  initial forever begin
    @(posedge iClk);
    cyc++;
  end

  // Output monitor
  initial begin
    logic fPrev;
    fPrev = 1'b0;
    forever begin
      @(negedge iClk);
      if (oRd_en) begin
        rdCyc.push_back(cyc);
        rdAddr.push_back(oAddr);
      end
      if (oCur_valid) begin
        curIv.push_back(oIv);
        curIu.push_back(oIu);
      end
      if (oAux_valid) begin
        auxChQ.push_back(oAux_ch);
        auxValQ.push_back(oAux_ch ? oAux1 : oAux0);
      end
      if (oCur_overrun) ovrCnt++;
      if (oFault && !fPrev && faultCyc < 0) faultCyc = cyc;
      fPrev = oFault;
    end
  end

  // SPI reader model: answers each oRd_en after a random latency
  initial begin
    logic [1:0]  a;
    logic [11:0] d;
    int lat, ep, hold, forceIdx;
    bit aborted;
    forceIdx = 0;
    iRd_done = 1'b0;
    iData = '0;
    forever begin
      @(negedge iClk);
      if (iRst_n && oRd_en && !readerDead) begin
        a = oAddr; ep = rstEpoch; aborted = 1'b0;
        lat = $urandom_range(40, 20);
        for (int i = 0; i < lat && !aborted; i++) begin
          @(negedge iClk);
          if (rstEpoch != ep) aborted = 1'b1;
        end
        if (!aborted) begin
          if (forceIdx < forceQ.size()) begin
            d = forceQ[forceIdx];
            forceIdx++;
          end else begin
            d = 12'($urandom_range(4095, 0));
          end
          iData = d;
          iRd_done = 1'b1;
          hold = $urandom_range(2, 1);
          for (int i = 0; i < hold; i++) @(negedge iClk);
          iRd_done = 1'b0;
          if (rstEpoch == ep) begin
            logAddr.push_back(a);
            logData.push_back(d);
            fallCyc.push_back(cyc);
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int b, bl, bc, ba, ov0, c0, e, nTrig, expRr, viol, minGap, g, gapLen, nAux;
    logic [11:0] ivE[$], iuE[$], auxE[$];

    // Reset state
    repeat (3) @(negedge iClk);
    chkEq("rst_rden", oRd_en, 0);
    chkEq("rst_addr", oAddr, 0);
    chkEq("rst_data", {oIv, oIu, oAux0[7:0]}, 0);
    chkEq("rst_flags", {oCur_valid, oAux_valid, oAux_ch, oCur_overrun, oFault}, 0);
    iRst_n = 1'b1; iEn = 1'b1; expRr = 0;
    repeat (3) @(negedge iClk);

    // T1: trigger latency, fixed data, pair ordering and gap
    b = rdAddr.size(); bl = logAddr.size(); bc = curIv.size();
    forceQ.push_back(12'hA5A); forceQ.push_back(12'h123);
    iCurTrig = 1'b1;
    @(negedge iClk); chkEq("t1_lat_k0", oRd_en, 0);
    @(negedge iClk); chkEq("t1_lat_k1", oRd_en, 0);
    @(negedge iClk); chkEq("t1_lat_k2", oRd_en, 1); chkEq("t1_addr_iv", oAddr, 2);
    iCurTrig = 1'b0;
    waitQuiet("t1");
    chkEq("t1_nrd", rdAddr.size() - b, 2);
    if (rdAddr.size() >= b + 2 && fallCyc.size() > bl) begin
      chkEq("t1_addr_iu", rdAddr[b+1], 3);
      gapLen = rdCyc[b+1] - fallCyc[bl];
      chkEq("t1_gap_min", 32'(gapLen >= CS_GAP), 1);
      chkEq("t1_gap_max", 32'(gapLen <= CS_GAP + 3), 1);
    end
    chkEq("t1_ncur", curIv.size() - bc, 1);
    chkEq("t1_iv", oIv, 12'hA5A);
    chkEq("t1_iu", oIu, 12'h123);

    // T2: aux round-robin
    b = rdAddr.size(); bl = logAddr.size(); ba = auxChQ.size();
    iAuxReq = 1'b1;
    waitIssue(b + 3, "t2");
    iAuxReq = 1'b0;
    waitQuiet("t2");
    chkEq("t2_nrd", rdAddr.size() - b, 3);
    chkEq("t2_naux", auxChQ.size() - ba, 3);
    for (int i = 0; i < 3; i++) begin
      if (rdAddr.size() > b + i) chkEq("t2_addr", rdAddr[b+i], (expRr + i) % 2);
      if (auxChQ.size() > ba + i && logData.size() > bl + i) begin
        chkEq("t2_ch", auxChQ[ba+i], (expRr + i) % 2);
        chkEq("t2_val", auxValQ[ba+i], logData[bl+i]);
      end
    end
    if (logData.size() >= bl + 3) begin
      chkEq("t2_aux0", oAux0, logData[bl+2]);
      chkEq("t2_aux1", oAux1, logData[bl+1]);
    end
    expRr = (expRr + 3) % 2;

    // T3: trigger during aux transfer, pair follows, no aux interleave
    b = rdAddr.size(); bl = logAddr.size(); bc = curIv.size();
    iAuxReq = 1'b1;
    waitIssue(b + 1, "t3a");
    repeat (5) @(negedge iClk);
    trigPulse();
    waitIssue(b + 3, "t3b");
    iAuxReq = 1'b0;
    waitQuiet("t3");
    if (rdAddr.size() >= b + 3) begin
      chkEq("t3_addr0", rdAddr[b], expRr);
      chkEq("t3_addr1", rdAddr[b+1], 2);
      chkEq("t3_addr2", rdAddr[b+2], 3);
    end
    chkEq("t3_ncur", curIv.size() - bc, 1);
    if (curIv.size() > bc && logData.size() >= bl + 3) begin
      chkEq("t3_iv", curIv[bc], logData[bl+1]);
      chkEq("t3_iu", curIu[bc], logData[bl+2]);
    end
    nAux = 0;
    for (int i = b; i < rdAddr.size(); i++) if (rdAddr[i] < 2) nAux++;
    expRr = (expRr + nAux) % 2;

    // T4: second trigger while pair in progress is dropped
    b = rdAddr.size(); bc = curIv.size(); ov0 = ovrCnt;
    trigPulse();
    repeat (48) @(negedge iClk);
    trigPulse();
    waitQuiet("t4");
    chkEq("t4_ovr", ovrCnt - ov0, 1);
    chkEq("t4_nrd", rdAddr.size() - b, 2);
    chkEq("t4_ncur", curIv.size() - bc, 1);

    // T4b: iEn dropped mid-pair, pair completes; triggers ignored while disabled
    b = rdAddr.size(); bc = curIv.size(); ov0 = ovrCnt;
    trigPulse();
    waitIssue(b + 1, "t4b");
    iEn = 1'b0;
    waitQuiet("t4b_a");
    chkEq("t4b_nrd", rdAddr.size() - b, 2);
    chkEq("t4b_ncur", curIv.size() - bc, 1);
    trigPulse();
    repeat (5) @(negedge iClk);
    iEn = 1'b1;
    waitQuiet("t4b_b");
    chkEq("t4b_idle", rdAddr.size() - b, 2);
    chkEq("t4b_ovr", ovrCnt - ov0, 0);

    // T5: reader never answers -> timeout fault (wins over same-cycle clear)
    b = rdAddr.size(); bl = logAddr.size(); bc = curIv.size(); ov0 = ovrCnt;
    readerDead = 1'b1;
    trigPulse();
    waitIssue(b + 1, "t5");
    e = (rdCyc.size() > b) ? rdCyc[b] : cyc;
    while (cyc < e + TIMEOUT - 1) @(negedge iClk);
    chkEq("t5_prefault", oFault, 0);
    iFault_clr = 1'b1;
    @(negedge iClk);
    iFault_clr = 1'b0;
    chkEq("t5_fault", oFault, 1);
    chkEq("t5_fault_cyc", faultCyc, e + TIMEOUT);
    repeat (30) @(negedge iClk);
    trigPulse();
    repeat (60) @(negedge iClk);
    chkEq("t5_blocked", rdAddr.size() - b, 1);
    chkEq("t5_nocur", curIv.size() - bc, 0);
    chkEq("t5_ovr", ovrCnt - ov0, 0);
    chkEq("t5_sticky", oFault, 1);
    readerDead = 1'b0;
    iFault_clr = 1'b1;
    @(negedge iClk);
    iFault_clr = 1'b0;
    chkEq("t5_clr", oFault, 0);
    trigPulse();
    waitQuiet("t5");
    chkEq("t5_nrd", rdAddr.size() - b, 3);
    chkEq("t5_ncur", curIv.size() - bc, 1);
    if (curIv.size() > bc && logData.size() >= bl + 2) begin
      chkEq("t5_iv", curIv[bc], logData[bl]);
      chkEq("t5_iu", curIu[bc], logData[bl+1]);
    end

    // T6: asynchronous reset mid-transfer, clean restart
    b = rdAddr.size();
    trigPulse();
    waitIssue(b + 1, "t6a");
    repeat (5) @(negedge iClk);
    iRst_n = 1'b0;
    rstEpoch++;
    #1;
    chkEq("t6_rden", oRd_en, 0);
    chkEq("t6_addr", oAddr, 0);
    chkEq("t6_data", {oIv, oIu}, 0);
    chkEq("t6_aux", {oAux0, oAux1}, 0);
    chkEq("t6_fault", oFault, 0);
    repeat (3) @(negedge iClk);
    iRst_n = 1'b1;
    expRr = 0;
    repeat (5) @(negedge iClk);
    b = rdAddr.size(); bl = logAddr.size(); bc = curIv.size();
    c0 = cyc;
    trigPulse();
    waitQuiet("t6b");
    chkEq("t6_nrd", rdAddr.size() - b, 2);
    if (rdAddr.size() >= b + 2) begin
      chkEq("t6_lat", rdCyc[b] - c0, 3);
      chkEq("t6_addr0", rdAddr[b], 2);
      chkEq("t6_addr1", rdAddr[b+1], 3);
    end
    if (curIv.size() > bc && logData.size() >= bl + 2) begin
      chkEq("t6_iv", oIv, logData[bl]);
      chkEq("t6_iu", oIu, logData[bl+1]);
    end
    b = rdAddr.size();
    iAuxReq = 1'b1;
    waitIssue(b + 1, "t6c");
    iAuxReq = 1'b0;
    waitQuiet("t6c");
    if (rdAddr.size() > b) chkEq("t6_rr", rdAddr[b], 0);
    expRr = 1;

    // Randomized soak against the transaction-level model
    b = rdAddr.size(); bl = logAddr.size(); bc = curIv.size();
    ba = auxChQ.size(); ov0 = ovrCnt; nTrig = 0;
    for (int it = 0; it < 30; it++) begin
      iAuxReq = 1'($urandom_range(1, 0));
      repeat ($urandom_range(150, 3)) @(negedge iClk);
      trigPulse();
      nTrig++;
    end
    iAuxReq = 1'b0;
    waitQuiet("soak");
    for (int i = bl; i < logAddr.size(); i++) begin
      if (logAddr[i] == 2'd2)      ivE.push_back(logData[i]);
      else if (logAddr[i] == 2'd3) iuE.push_back(logData[i]);
      else                         auxE.push_back(logData[i]);
    end
    viol = 0;
    for (int i = b; i < rdAddr.size(); i++) begin
      if (rdAddr[i] == 2'd2 && (i + 1 >= rdAddr.size() || rdAddr[i+1] != 2'd3)) viol++;
      if (rdAddr[i] == 2'd3 && (i == b || rdAddr[i-1] != 2'd2)) viol++;
    end
    chkEq("soak_order", viol, 0);
    minGap = 1000000;
    for (int i = b; i + 1 < rdAddr.size(); i++) begin
      if (bl + (i - b) < fallCyc.size()) begin
        g = rdCyc[i+1] - fallCyc[bl + (i - b)];
        if (g < minGap) minGap = g;
      end
    end
    chkEq("soak_gap", 32'(minGap >= CS_GAP), 1);
    chkEq("soak_npair", curIv.size() - bc, ivE.size());
    chkEq("soak_conserve", nTrig, ivE.size() + (ovrCnt - ov0));
    for (int i = 0; i < ivE.size() && i < iuE.size() && bc + i < curIv.size(); i++) begin
      chkEq("soak_iv", curIv[bc+i], ivE[i]);
      chkEq("soak_iu", curIu[bc+i], iuE[i]);
    end
    chkEq("soak_naux", auxChQ.size() - ba, auxE.size());
    for (int i = 0; i < auxE.size() && ba + i < auxChQ.size(); i++) begin
      chkEq("soak_auxch", auxChQ[ba+i], (expRr + i) % 2);
      chkEq("soak_auxval", auxValQ[ba+i], auxE[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
